// File: rtl/fetch_buffer_pkg.sv
// Shared widths, the FIFO entry layout and the PC increment helper for the
// instruction-fetch front end.
package fetch_buffer_pkg;

    localparam int PC_W            = 16;
    localparam int WADDR_W         = 15;
    localparam int MEM_LAT_DEFAULT = 2;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] inst;
    } fetch_entry_t;

    // Next sequential halfword-aligned PC; 16'hFFFE rolls over to 16'h0000.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return (pc & 16'hFFFE) + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Valid/ready link from the fetch buffer to decode. The fetch side is the
// master and drives the word; decode is the slave and drives ready.
interface fetch_buffer_if;
    import fetch_buffer_pkg::*;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_inst;
    logic [PC_W-1:0] out_pc;

    modport master (output out_valid, output out_inst, output out_pc, input out_ready);
    modport slave  (input out_valid, input out_inst, input out_pc, output out_ready);

endinterface

// File: rtl/fetch_buffer_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, inst} records with a first-word view.
// Flush beats push and pop. Written generically so it can also back a load queue.
module fetch_buffer_fifo
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic [CNT_W-1:0] count,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign push_s = push & (count_r != CNT_W'(DEPTH));
    assign pop_s  = pop & (count_r != '0);
    assign head   = mem_r[rd_ptr_r];
    assign count  = count_r;
    assign empty  = (count_r == '0);

    // Storage, pointers and occupancy; reset also clears the storage so the head reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Sequential instruction fetch: streams word addresses into a fixed-latency
// memory with no stall, tracks in-flight reads and queues returns for decode.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              MEM_LAT  = MEM_LAT_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [WADDR_W-1:0] mem_raddr,
    input  logic [PC_W-1:0]    mem_rdata,
    fetch_buffer_if.master     dec_if
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IFL_W = $clog2(MEM_LAT + 1);
    localparam int SUM_W = $clog2(DEPTH + MEM_LAT + 1);

    logic [PC_W-1:0]  fetch_pc_r;
    logic [MEM_LAT-1:0] sr_valid_r;
    logic [PC_W-1:0]  sr_pc_r [MEM_LAT];
    logic [IFL_W-1:0] inflight_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_empty_s;
    logic             issue_s;
    logic             push_s;
    logic             pop_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_s;

    // Number of reads currently travelling through the memory pipeline.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight_s = inflight_s + IFL_W'(sr_valid_r[i]);
        end
    end

    // Credit check ignores a same-cycle pop: a read may only start if its
    // return slot is already guaranteed, since the memory cannot be stalled.
    assign issue_s = rst_n & ~redirect_valid &
                     ((SUM_W'(fifo_count_s) + SUM_W'(inflight_s)) < SUM_W'(DEPTH));

    assign mem_raddr = fetch_pc_r[PC_W-1:1];
    assign push_s    = sr_valid_r[MEM_LAT-1];
    assign pop_s     = dec_if.out_valid & dec_if.out_ready;

    // Pair the returning word with the PC that requested it.
    always_comb begin
        push_entry_s      = '0;
        push_entry_s.pc   = sr_pc_r[MEM_LAT-1];
        push_entry_s.inst = mem_rdata;
    end

    // Fetch PC and the in-flight valid/PC shift register; redirect clears every valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC & 16'hFFFE;
            sr_valid_r <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                sr_pc_r[i] <= '0;
            end
        end else begin
            sr_valid_r[0] <= issue_s;
            sr_pc_r[0]    <= fetch_pc_r;
            for (int i = 1; i < MEM_LAT; i++) begin
                sr_valid_r[i] <= sr_valid_r[i-1] & ~redirect_valid;
                sr_pc_r[i]    <= sr_pc_r[i-1];
            end
            if (redirect_valid) begin
                fetch_pc_r <= redirect_pc & 16'hFFFE;
            end else if (issue_s) begin
                fetch_pc_r <= pc_inc(fetch_pc_r);
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
        end
    end

    fetch_buffer_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_valid),
        .wdata (push_entry_s),
        .head  (head_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    assign dec_if.out_valid = ~fifo_empty_s;
    assign dec_if.out_inst  = head_s.inst;
    assign dec_if.out_pc    = head_s.pc;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: 2-cycle memory model holding word[i]=16'hA000+i,
// a delivery scoreboard, and a redirect vector table plus reset/backpressure sequences.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic [15:0] mem_d1;

    fetch_buffer_if dec_if ();

    fetch_buffer #(
        .DEPTH    (4),
        .MEM_LAT  (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .dec_if         (dec_if)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [14:0] a);
        return 16'hA000 + {1'b0, a};
    endfunction

    // Memory with a fixed two-cycle read latency and no stall.
    always @(posedge clk) begin
        mem_d1    <= mem_word(mem_raddr);
        mem_rdata <= mem_d1;
    end

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
    } exp_t;

    typedef struct {
        logic [15:0] rpc;
        logic        rdy;
        logic [15:0] exp_pc;
        logic [15:0] exp_inst;
        int          exp_lat;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total  = 0;
    int   passed = 0;
    int   xfers  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected delivery order from a fresh start PC, counting on 16-bit wrap.
    task automatic sb_restart(input logic [15:0] pc);
        logic [15:0] p;
        sb_q.delete();
        xfers = 0;
        p = pc & 16'hFFFE;
        for (int i = 0; i < 64; i++) begin
            sb_q.push_back('{pc: p, inst: mem_word(p[15:1])});
            p = p + 16'd2;
        end
    endtask

    // Every completed handshake must be the next expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dec_if.out_valid === 1'b1 && dec_if.out_ready === 1'b1) begin
            xfers++;
            if (sb_q.size() == 0) begin
                total++;
                $display("FAIL sb_underflow: got pc %h with no expected word", dec_if.out_pc);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_pc", 32'(dec_if.out_pc), 32'(mon_e.pc));
                check("sb_inst", 32'(dec_if.out_inst), 32'(mon_e.inst));
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clk);
        while (dec_if.out_valid !== 1'b1 && lat < 20) begin
            adv();
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic stream(input int n, output int gaps);
        gaps = 0;
        for (int i = 0; i < n; i++) begin
            adv();
            dec_if.out_ready = 1'b1;
            @(negedge clk);
            if (dec_if.out_valid !== 1'b1) gaps++;
        end
    endtask

    vec_t vecs[4];
    int   lat;
    int   gaps;

    initial begin
        vecs[0] = '{rpc: 16'h0101, rdy: 1'b0, exp_pc: 16'h0100, exp_inst: 16'hA080, exp_lat: 4};
        vecs[1] = '{rpc: 16'hFFFC, rdy: 1'b0, exp_pc: 16'hFFFC, exp_inst: 16'h1FFE, exp_lat: 4};
        vecs[2] = '{rpc: 16'h0040, rdy: 1'b1, exp_pc: 16'h0040, exp_inst: 16'hA020, exp_lat: 4};
        vecs[3] = '{rpc: 16'h1235, rdy: 1'b1, exp_pc: 16'h1234, exp_inst: 16'hA91A, exp_lat: 4};

        rst_n            = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = 16'h0000;
        dec_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(dec_if.out_valid), 32'd0);
        check("rst_inst", 32'(dec_if.out_inst), 32'd0);
        check("rst_pc", 32'(dec_if.out_pc), 32'd0);
        check("rst_raddr", 32'(mem_raddr), 32'd0);

        // Start-up latency and streaming
        adv();
        rst_n = 1'b1;
        sb_restart(16'h0000);
        wait_valid(lat);
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_first_pc", 32'(dec_if.out_pc), 32'h0000);
        check("t1_first_inst", 32'(dec_if.out_inst), 32'hA000);
        stream(10, gaps);
        check("t1_gaps", 32'(gaps), 32'd0);

        // Backpressure: exactly DEPTH words issued beyond those delivered
        adv();
        dec_if.out_ready = 1'b0;
        repeat (9) adv();
        @(negedge clk);
        check("t2_valid_held", 32'(dec_if.out_valid), 32'd1);
        check("t2_full_raddr", 32'(mem_raddr), 32'(xfers + 4));
        stream(12, gaps);
        check("t2_gaps", 32'(gaps), 32'd0);

        // Redirect vectors, with and without a transfer in the redirect cycle
        for (int i = 0; i < 4; i++) begin
            stream(4, gaps);
            adv();
            dec_if.out_ready = 1'b0;
            adv();
            adv();
            dec_if.out_ready = vecs[i].rdy;
            redirect_valid   = 1'b1;
            redirect_pc      = vecs[i].rpc;
            @(negedge clk);
            check("redir_queue_busy", 32'(dec_if.out_valid), 32'd1);
            adv();
            redirect_valid   = 1'b0;
            dec_if.out_ready = 1'b1;
            sb_restart(vecs[i].rpc);
            wait_valid(lat);
            check("redir_latency", 32'(lat + 1), 32'(vecs[i].exp_lat));
            check("redir_first_pc", 32'(dec_if.out_pc), 32'(vecs[i].exp_pc));
            check("redir_first_inst", 32'(dec_if.out_inst), 32'(vecs[i].exp_inst));
            stream(6, gaps);
            check("redir_gaps", 32'(gaps), 32'd0);
        end

        // One-cycle reset mid-stream with a full queue
        stream(3, gaps);
        adv();
        dec_if.out_ready = 1'b0;
        repeat (8) adv();
        rst_n = 1'b0;
        adv();
        rst_n            = 1'b1;
        dec_if.out_ready = 1'b1;
        sb_restart(16'h0000);
        @(negedge clk);
        check("t6_valid", 32'(dec_if.out_valid), 32'd0);
        check("t6_inst", 32'(dec_if.out_inst), 32'd0);
        check("t6_pc", 32'(dec_if.out_pc), 32'd0);
        check("t6_raddr", 32'(mem_raddr), 32'd0);
        adv();
        wait_valid(lat);
        check("t6_latency", 32'(lat), 32'd2);
        check("t6_first_inst", 32'(dec_if.out_inst), 32'hA000);
        stream(5, gaps);
        check("t6_gaps", 32'(gaps), 32'd0);

        adv();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
